// File: rtl/ni_req_channel_arbiter_pkg.sv
// Shared constants for the NI request-channel arbiter: flit width default,
// FSM state encodings and stream identifiers.
package ni_req_channel_arbiter_pkg;

    localparam int FLIT_WIDTH_DEF      = 80;
    localparam int MAX_OUTSTANDING_DEF = 16;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE   = 2'd0;
    localparam arb_state_t ARB_WR_PKT = 2'd1;
    localparam arb_state_t ARB_RD_PKT = 2'd2;

    localparam logic ARB_WR = 1'b0;
    localparam logic ARB_RD = 1'b1;

    function automatic int outs_cnt_width(input int max_outs);
        return $clog2(max_outs + 1);
    endfunction

endpackage

// File: rtl/ni_req_channel_arbiter_outs_counter.sv
// ni_outs_counter: saturating up/down in-flight packet counter with a sticky
// underflow flag raised when a decrement arrives at zero.
module ni_outs_counter
    import ni_req_channel_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int CNTW            = outs_cnt_width(MAX_OUTSTANDING)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CNTW-1:0] count_o,
    output logic            underflow_o
);

    logic [CNTW-1:0] count_q, count_d;
    logic            underflow_q, underflow_d;

    // Simultaneous inc and dec cancel out and leave the count untouched.
    always_comb begin
        count_d     = count_q;
        underflow_d = underflow_q;
        if (inc_i && !dec_i) begin
            if (count_q != CNTW'(MAX_OUTSTANDING)) begin
                count_d = count_q + CNTW'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_o     = count_q;
    assign underflow_o = underflow_q;

endmodule

// File: rtl/ni_req_channel_arbiter.sv
// Packet-granular arbiter sharing the out_buffer write port between write and
// read request streams. Define NI_ARB_RD_FIXED_PRIO_EN to give reads fixed tie priority.
module ni_req_channel_arbiter
    import ni_req_channel_arbiter_pkg::*;
#(
    parameter  int FLIT_WIDTH      = FLIT_WIDTH_DEF,
    parameter  int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    localparam int CNTW            = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] wr_flit,
    input  logic                  wr_valid,
    input  logic                  wr_last,
    output logic                  wr_ready,
    input  logic [FLIT_WIDTH-1:0] rd_flit,
    input  logic                  rd_valid,
    input  logic                  rd_last,
    output logic                  rd_ready,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  write_out,
    input  logic                  full_in,
    input  logic                  decr_wr,
    input  logic                  decr_rd,
    output logic [CNTW-1:0]       wr_outs,
    output logic [CNTW-1:0]       rd_outs,
    output logic                  underflow_err
);

    arb_state_t state_q, state_d;
    logic       elig_wr, elig_rd;
    logic       grant_valid, grant_sel, grant_last, accept;
    logic       head_acc_wr, head_acc_rd;
    logic       uf_wr, uf_rd;

`ifndef NI_ARB_RD_FIXED_PRIO_EN
    logic       rr_ptr_q, rr_ptr_d;
`endif

    assign elig_wr = wr_valid && (wr_outs < CNTW'(MAX_OUTSTANDING));
    assign elig_rd = rd_valid && (rd_outs < CNTW'(MAX_OUTSTANDING));

    // Caps gate only the head decision; an open packet is served regardless.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = ARB_WR;
        case (state_q)
            ARB_IDLE: begin
                if (elig_wr && elig_rd) begin
                    grant_valid = 1'b1;
`ifdef NI_ARB_RD_FIXED_PRIO_EN
                    grant_sel   = ARB_RD;
`else
                    grant_sel   = rr_ptr_q;
`endif
                end else if (elig_wr) begin
                    grant_valid = 1'b1;
                    grant_sel   = ARB_WR;
                end else if (elig_rd) begin
                    grant_valid = 1'b1;
                    grant_sel   = ARB_RD;
                end
            end
            ARB_WR_PKT: begin
                grant_valid = wr_valid;
                grant_sel   = ARB_WR;
            end
            ARB_RD_PKT: begin
                grant_valid = rd_valid;
                grant_sel   = ARB_RD;
            end
            default: begin
                grant_valid = 1'b0;
                grant_sel   = ARB_WR;
            end
        endcase
    end

    assign accept     = grant_valid && !full_in && rst;
    assign grant_last = (grant_sel == ARB_RD) ? rd_last : wr_last;
    assign wr_ready   = accept && (grant_sel == ARB_WR);
    assign rd_ready   = accept && (grant_sel == ARB_RD);
    assign write_out  = accept;
    assign flit_out   = !grant_valid ? '0 : ((grant_sel == ARB_RD) ? rd_flit : wr_flit);

    assign head_acc_wr = wr_ready && (state_q == ARB_IDLE);
    assign head_acc_rd = rd_ready && (state_q == ARB_IDLE);

    always_comb begin
        state_d  = state_q;
`ifndef NI_ARB_RD_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        if (accept) begin
            if (grant_last) begin
                state_d  = ARB_IDLE;
`ifndef NI_ARB_RD_FIXED_PRIO_EN
                rr_ptr_d = ~grant_sel;
`endif
            end else begin
                state_d  = (grant_sel == ARB_RD) ? ARB_RD_PKT : ARB_WR_PKT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
`ifndef NI_ARB_RD_FIXED_PRIO_EN
            rr_ptr_q <= ARB_WR;
`endif
        end else begin
            state_q  <= state_d;
`ifndef NI_ARB_RD_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    ni_outs_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNTW            (CNTW)
    ) u_wr_outs (
        .clk         (clk),
        .rst_n       (rst),
        .inc_i       (head_acc_wr),
        .dec_i       (decr_wr),
        .count_o     (wr_outs),
        .underflow_o (uf_wr)
    );

    ni_outs_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNTW            (CNTW)
    ) u_rd_outs (
        .clk         (clk),
        .rst_n       (rst),
        .inc_i       (head_acc_rd),
        .dec_i       (decr_rd),
        .count_o     (rd_outs),
        .underflow_o (uf_rd)
    );

    assign underflow_err = uf_wr || uf_rd;

endmodule

// File: tb/tb_ni_req_channel_arbiter.sv
// Table-driven bench for ni_req_channel_arbiter with a flit-order scoreboard.
// Expectations follow NI_ARB_RD_FIXED_PRIO_EN when that macro is defined.
module tb_ni_req_channel_arbiter;

    localparam int FW   = 80;
    localparam int MAXO = 2;
    localparam int CNTW = $clog2(MAXO + 1);
`ifdef NI_ARB_RD_FIXED_PRIO_EN
    localparam bit RP = 1'b1;
`else
    localparam bit RP = 1'b0;
`endif

    logic            clk, rst;
    logic [FW-1:0]   wr_flit, rd_flit, flit_out;
    logic            wr_valid, wr_last, wr_ready;
    logic            rd_valid, rd_last, rd_ready;
    logic            write_out, full_in, decr_wr, decr_rd, underflow_err;
    logic [CNTW-1:0] wr_outs, rd_outs;

    int checks = 0;
    int errors = 0;
    int wr_idx = 0;
    int rd_idx = 0;
    logic [FW-1:0] sb[$];

    typedef struct {
        logic wv, wl, rv, rl, full, dw, dr;
        logic ewr, err;
        int   ew, er;
        logic euf;
    } vec_t;

    vec_t tbl[$];

    ni_req_channel_arbiter #(
        .FLIT_WIDTH      (FW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_flit       (wr_flit),
        .wr_valid      (wr_valid),
        .wr_last       (wr_last),
        .wr_ready      (wr_ready),
        .rd_flit       (rd_flit),
        .rd_valid      (rd_valid),
        .rd_last       (rd_last),
        .rd_ready      (rd_ready),
        .flit_out      (flit_out),
        .write_out     (write_out),
        .full_in       (full_in),
        .decr_wr       (decr_wr),
        .decr_rd       (decr_rd),
        .wr_outs       (wr_outs),
        .rd_outs       (rd_outs),
        .underflow_err (underflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t V(input logic wv, wl, rv, rl, full, dw, dr,
                               input logic ewr, err, input int ew, er, input logic euf);
        vec_t v;
        v.wv = wv; v.wl = wl; v.rv = rv; v.rl = rl; v.full = full;
        v.dw = dw; v.dr = dr; v.ewr = ewr; v.err = err;
        v.ew = ew; v.er = er; v.euf = euf;
        return v;
    endfunction

    function automatic logic [FW-1:0] wflit(input int i);
        return {8'hA5, 56'h0, 16'(i)};
    endfunction

    function automatic logic [FW-1:0] rflit(input int i);
        return {8'h5D, 56'h0, 16'(i)};
    endfunction

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, then counters after the edge.
    task automatic step(input vec_t v);
        logic [FW-1:0] exp_flit;
        @(negedge clk);
        wr_valid = v.wv; wr_last = v.wl; rd_valid = v.rv; rd_last = v.rl;
        full_in  = v.full; decr_wr = v.dw; decr_rd = v.dr;
        wr_flit  = wflit(wr_idx);
        rd_flit  = rflit(rd_idx);
        if (v.ewr) sb.push_back(wflit(wr_idx));
        if (v.err) sb.push_back(rflit(rd_idx));
        #1;
        chk("wr_ready", FW'(wr_ready), FW'(v.ewr));
        chk("rd_ready", FW'(rd_ready), FW'(v.err));
        chk("write_out", FW'(write_out), FW'(v.ewr | v.err));
        if (write_out) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", FW'(1), FW'(0));
            end else begin
                exp_flit = sb.pop_front();
                chk("flit_out", flit_out, exp_flit);
            end
        end
        if (!v.wv && !v.rv) chk("flit_out_idle", flit_out, '0);
        $display("cycle wv=%0b rv=%0b full=%0b dw=%0b dr=%0b -> wr_ready=%0b rd_ready=%0b flit=%0h",
                 v.wv, v.rv, v.full, v.dw, v.dr, wr_ready, rd_ready, flit_out);
        if (v.ewr) wr_idx++;
        if (v.err) rd_idx++;
        @(posedge clk);
        #1;
        chk("wr_outs", FW'(wr_outs), FW'(v.ew));
        chk("rd_outs", FW'(rd_outs), FW'(v.er));
        chk("underflow_err", FW'(underflow_err), FW'(v.euf));
    endtask

    initial begin
        rst = 1'b0;
        wr_valid = 1'b1; wr_last = 1'b1; rd_valid = 1'b1; rd_last = 1'b1;
        full_in = 1'b0; decr_wr = 1'b0; decr_rd = 1'b0;
        wr_flit = '0; rd_flit = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr_ready", FW'(wr_ready), '0);
        chk("rst_rd_ready", FW'(rd_ready), '0);
        chk("rst_write_out", FW'(write_out), '0);
        chk("rst_wr_outs", FW'(wr_outs), '0);
        chk("rst_rd_outs", FW'(rd_outs), '0);
        chk("rst_underflow", FW'(underflow_err), '0);
        @(negedge clk);
        rst = 1'b1;
        wr_valid = 1'b0; rd_valid = 1'b0;

        // Both streams single-flit every cycle: round-robin (or read priority) then caps.
        tbl.push_back(V(1,1,1,1,0,0,0, !RP, RP,  RP ? 0 : 1, RP ? 1 : 0, 0));
        tbl.push_back(V(1,1,1,1,0,0,0, 0, 1,     RP ? 0 : 1, RP ? 2 : 1, 0));
        tbl.push_back(V(1,1,1,1,0,0,0, 1, 0,     RP ? 1 : 2, RP ? 2 : 1, 0));
        tbl.push_back(V(1,1,1,1,0,0,0, RP, !RP,  2, 2, 0));
        tbl.push_back(V(0,0,0,0,0,1,1, 0,0, 1,1, 0));
        tbl.push_back(V(0,0,0,0,0,1,1, 0,0, 0,0, 0));
        // 4-flit write packet locks out reads until the tail.
        tbl.push_back(V(1,0,0,0,0,0,0, 1,0, 1,0, 0));
        tbl.push_back(V(1,0,1,1,0,0,0, 1,0, 1,0, 0));
        tbl.push_back(V(1,0,1,1,0,0,0, 1,0, 1,0, 0));
        tbl.push_back(V(1,1,1,1,0,0,0, 1,0, 1,0, 0));
        tbl.push_back(V(0,0,1,1,0,0,0, 0,1, 1,1, 0));
        tbl.push_back(V(0,0,0,0,0,1,1, 0,0, 0,0, 0));
        // full_in stall mid write packet.
        tbl.push_back(V(1,0,0,0,0,0,0, 1,0, 1,0, 0));
        tbl.push_back(V(1,0,1,1,1,0,0, 0,0, 1,0, 0));
        tbl.push_back(V(1,0,1,1,1,0,0, 0,0, 1,0, 0));
        tbl.push_back(V(1,0,1,1,1,0,0, 0,0, 1,0, 0));
        tbl.push_back(V(1,0,1,1,0,0,0, 1,0, 1,0, 0));
        tbl.push_back(V(1,1,1,1,0,0,0, 1,0, 1,0, 0));
        tbl.push_back(V(0,0,1,1,0,0,0, 0,1, 1,1, 0));
        tbl.push_back(V(0,0,0,0,0,1,1, 0,0, 0,0, 0));
        // Read cap of 2, released by a decrement.
        tbl.push_back(V(0,0,1,1,0,0,0, 0,1, 0,1, 0));
        tbl.push_back(V(0,0,1,1,0,0,0, 0,1, 0,2, 0));
        tbl.push_back(V(0,0,1,1,0,0,0, 0,0, 0,2, 0));
        tbl.push_back(V(0,0,1,1,0,0,1, 0,0, 0,1, 0));
        tbl.push_back(V(0,0,1,1,0,0,0, 0,1, 0,2, 0));
        // Underflow, then simultaneous head accept and decrement.
        tbl.push_back(V(0,0,0,0,0,1,0, 0,0, 0,2, 1));
        tbl.push_back(V(0,0,0,0,0,0,1, 0,0, 0,1, 1));
        tbl.push_back(V(0,0,1,1,0,0,1, 0,1, 0,1, 1));
        tbl.push_back(V(0,0,0,0,0,0,1, 0,0, 0,0, 1));
        // Open a read packet to be cut by reset.
        tbl.push_back(V(0,0,1,0,0,0,0, 0,1, 0,1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Reset mid read packet: outputs gated, counters and flag cleared.
        @(negedge clk);
        rst = 1'b0;
        wr_valid = 1'b1; wr_last = 1'b1; rd_valid = 1'b1; rd_last = 1'b1;
        #1;
        chk("mid_rst_wr_ready", FW'(wr_ready), '0);
        chk("mid_rst_rd_ready", FW'(rd_ready), '0);
        chk("mid_rst_write_out", FW'(write_out), '0);
        chk("mid_rst_rd_outs", FW'(rd_outs), '0);
        chk("mid_rst_underflow", FW'(underflow_err), '0);
        @(negedge clk);
        rst = 1'b1;
        wr_valid = 1'b0; rd_valid = 1'b0;

        // A lone write is accepted only if the read lock was dropped.
        step(V(1,1,0,0,0,0,0, 1,0, 1,0, 0));
        step(V(1,1,1,1,0,0,0, 0,1, 1,1, 0));
        step(V(1,1,1,1,0,0,0, !RP, RP, RP ? 1 : 2, RP ? 2 : 1, 0));

        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b0; decr_wr = 1'b0; decr_rd = 1'b0; full_in = 1'b0;
        chk("sb_empty", FW'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
